// File: rtl/calc_pkg.sv
// Shared types and sizing for the binary-to-BCD result converter.
package calc_pkg;

   localparam int unsigned BCD_W      = 4;
   localparam int unsigned NUM_DIGITS = 3;
   localparam int unsigned BIN_W      = 8;
   localparam int unsigned NUM_ITER   = 8;
   localparam int unsigned ACC_W      = BCD_W * NUM_DIGITS;
   localparam int unsigned CNT_W      = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   // Display enables {hundreds, tens, ones}; blanking hides leading zeros only.
   function automatic logic [NUM_DIGITS-1:0] digit_enable(
      input logic [BCD_W-1:0] hundreds,
      input logic [BCD_W-1:0] tens,
      input bit               lz_blank
   );
      logic [NUM_DIGITS-1:0] en;
      if (lz_blank) begin
         en = {(hundreds != '0), (hundreds != '0) || (tens != '0), 1'b1};
      end else begin
         en = '1;
      end
      return en;
   endfunction

endpackage

// File: rtl/bcd_adj3.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_adj3
   import calc_pkg::*;
(
   input  logic [BCD_W-1:0] d_i,
   output logic [BCD_W-1:0] d_o
);

   assign d_o = (d_i >= BCD_W'(5)) ? d_i + BCD_W'(3) : d_i;

endmodule

// File: rtl/result_bcd_conv.sv
// Sequential 8-bit binary to 3-digit BCD converter (shift-and-add-3),
// fixed 8-cycle latency with valid/ready handshakes on both sides.
module result_bcd_conv
   import calc_pkg::*;
#(
   parameter bit LZ_BLANK = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [BIN_W-1:0]      bin_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [BCD_W-1:0]      bcd_hundreds,
   output logic [BCD_W-1:0]      bcd_tens,
   output logic [BCD_W-1:0]      bcd_ones,
   output logic [NUM_DIGITS-1:0] digit_en
);

   state_e                state_q, state_d;
   logic [BIN_W-1:0]      sr_q, sr_d;
   logic [ACC_W-1:0]      acc_q, acc_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [BCD_W-1:0]      hun_q, hun_d;
   logic [BCD_W-1:0]      ten_q, ten_d;
   logic [BCD_W-1:0]      one_q, one_d;
   logic [NUM_DIGITS-1:0] den_q, den_d;
   logic                  out_valid_q, out_valid_d;
   logic                  in_ready_q, in_ready_d;

   logic [ACC_W-1:0]       acc_adj;
   logic [ACC_W+BIN_W-1:0] shift_w;
   logic [ACC_W-1:0]       acc_sh;
   logic [BIN_W-1:0]       sr_sh;

   // One corrector per BCD digit of the accumulator.
   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
      bcd_adj3 u_adj (
         .d_i (acc_q[g*BCD_W +: BCD_W]),
         .d_o (acc_adj[g*BCD_W +: BCD_W])
      );
   end

   assign shift_w = {acc_adj, sr_q} << 1;
   assign acc_sh  = shift_w[ACC_W+BIN_W-1:BIN_W];
   assign sr_sh   = shift_w[BIN_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         sr_q        <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         hun_q       <= '0;
         ten_q       <= '0;
         one_q       <= '0;
         den_q       <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         hun_q       <= hun_d;
         ten_q       <= ten_d;
         one_q       <= one_d;
         den_q       <= den_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      sr_d        = sr_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      hun_d       = hun_q;
      ten_d       = ten_q;
      one_d       = one_q;
      den_d       = den_q;
      out_valid_d = out_valid_q;

      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               sr_d    = bin_in;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            acc_d = acc_sh;
            sr_d  = sr_sh;
            cnt_d = cnt_q + CNT_W'(1);
            // Last iteration: publish the finished accumulator directly.
            if (cnt_q == CNT_W'(NUM_ITER - 1)) begin
               state_d     = DONE;
               hun_d       = acc_sh[2*BCD_W +: BCD_W];
               ten_d       = acc_sh[1*BCD_W +: BCD_W];
               one_d       = acc_sh[0 +: BCD_W];
               den_d       = digit_enable(acc_sh[2*BCD_W +: BCD_W],
                                          acc_sh[1*BCD_W +: BCD_W], LZ_BLANK);
               out_valid_d = 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
            end
         end
         default: begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
         end
      endcase

      in_ready_d = (state_d == IDLE);
   end

   assign in_ready     = in_ready_q;
   assign out_valid    = out_valid_q;
   assign bcd_hundreds = hun_q;
   assign bcd_tens     = ten_q;
   assign bcd_ones     = one_q;
   assign digit_en     = den_q;

endmodule

// File: tb/tb_result_bcd_conv.sv
// Scoreboard bench for result_bcd_conv: accepted inputs queue decimal
// expectations, a monitor checks each completed conversion.
module tb_result_bcd_conv;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] bin_in = 8'd0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [3:0] bcd_hundreds, bcd_tens, bcd_ones;
   logic [2:0] digit_en;

   result_bcd_conv #(.LZ_BLANK(1'b1)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .bin_in       (bin_in),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .bcd_hundreds (bcd_hundreds),
      .bcd_tens     (bcd_tens),
      .bcd_ones     (bcd_ones),
      .digit_en     (digit_en)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         v;
      int         h;
      int         t;
      int         o;
      logic [2:0] den;
      int         cyc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   acc_count = 0;
   int   last_acc_cyc = 0;
   bit   rand_stall = 1'b0;
   bit   prev_valid = 1'b0;
   logic [3:0] held_h, held_t, held_o;
   logic [2:0] held_den;

   // Reference: plain decimal arithmetic on the accepted value.
   function automatic exp_t model(input int v, input int c);
      exp_t e;
      e.v   = v;
      e.h   = v / 100;
      e.t   = (v / 10) % 10;
      e.o   = v % 10;
      e.den = {(v >= 100), (v >= 10), 1'b1};
      e.cyc = c;
      return e;
   endfunction

   task automatic check_eq(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Acceptor: record every transfer the DUT takes.
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (rst_n && in_valid && in_ready) begin
         sb.push_back(model(int'(bin_in), cyc));
         acc_count++;
         last_acc_cyc = cyc;
      end
   end

   always @(negedge rst_n) sb.delete();

   always @(negedge clk) begin
      if (rand_stall) out_ready = ($urandom_range(0, 3) != 0);
   end

   // Monitor: compare on each rising out_valid, hold-check while stalled.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         prev_valid = 1'b0;
      end else begin
         if (out_valid && !prev_valid) begin
            if (sb.size() == 0) begin
               check_eq("spurious_out_valid", 1, 0);
            end else begin
               e = sb.pop_front();
               check_eq($sformatf("hundreds[%0d]", e.v), int'(bcd_hundreds), e.h);
               check_eq($sformatf("tens[%0d]", e.v), int'(bcd_tens), e.t);
               check_eq($sformatf("ones[%0d]", e.v), int'(bcd_ones), e.o);
               check_eq($sformatf("digit_en[%0d]", e.v), int'(digit_en), int'(e.den));
               check_eq($sformatf("latency[%0d]", e.v), cyc - e.cyc, 8);
            end
            held_h = bcd_hundreds; held_t = bcd_tens;
            held_o = bcd_ones; held_den = digit_en;
         end else if (out_valid && prev_valid) begin
            check_eq("hold_stable", int'({bcd_hundreds, bcd_tens, bcd_ones, digit_en}),
                     int'({held_h, held_t, held_o, held_den}));
         end
         prev_valid = out_valid;
      end
   end

   task automatic send(input logic [7:0] v, input bit noise);
      int t;
      @(negedge clk);
      in_valid = 1'b1;
      bin_in   = v;
      t = 0;
      while (!in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) check_eq("send_timeout", 0, 1);
      @(negedge clk);
      in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      bin_in   = 8'($urandom);
      if (noise) begin
         @(negedge clk);
         in_valid = 1'b0;
         bin_in   = 8'($urandom);
      end
   endtask

   task automatic wait_valid();
      int t = 0;
      while (!out_valid && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!out_valid) check_eq("wait_valid_timeout", 0, 1);
   endtask

   task automatic drain();
      int t = 0;
      while ((sb.size() != 0 || out_valid || !in_ready) && t < 400) begin
         @(negedge clk);
         t++;
      end
      if (t >= 400) check_eq("drain_timeout", 0, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0, a0, a1, t, seen;

      // Reset values, observed while reset is held.
      #1 rst_n = 1'b0;
      #2;
      check_eq("rst_out_valid", int'(out_valid), 0);
      check_eq("rst_in_ready", int'(in_ready), 1);
      check_eq("rst_hundreds", int'(bcd_hundreds), 0);
      check_eq("rst_tens", int'(bcd_tens), 0);
      check_eq("rst_ones", int'(bcd_ones), 0);
      check_eq("rst_digit_en", int'(digit_en), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // 225 with out_ready held: single-cycle pulse.
      out_ready = 1'b1;
      send(8'd225, 1'b0);
      wait_valid();
      @(negedge clk);
      check_eq("one_cycle_pulse", int'(out_valid), 0);
      drain();

      send(8'd0, 1'b0);
      drain();
      send(8'd9, 1'b1);
      drain();

      // Backpressure on 255 with ignored in_valid pulses.
      out_ready = 1'b0;
      send(8'd255, 1'b1);
      wait_valid();
      n0 = acc_count;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         bin_in   = 8'($urandom);
         @(negedge clk);
         check_eq("bp_valid", int'(out_valid), 1);
         check_eq("bp_digits", int'({bcd_hundreds, bcd_tens, bcd_ones}), 'h255);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check_eq("bp_release_valid", int'(out_valid), 0);
      check_eq("bp_release_ready", int'(in_ready), 1);
      check_eq("bp_no_accept", acc_count, n0);
      drain();

      // Back-to-back 4 then 16 with in_valid held.
      @(negedge clk);
      in_valid = 1'b1;
      bin_in   = 8'd4;
      n0 = acc_count;
      t = 0;
      while (acc_count == n0 && t < 50) begin @(negedge clk); t++; end
      a0 = last_acc_cyc;
      bin_in = 8'd16;
      t = 0;
      while (acc_count == n0 + 1 && t < 50) begin @(negedge clk); t++; end
      a1 = last_acc_cyc;
      in_valid = 1'b0;
      check_eq("b2b_spacing", a1 - a0, 10);
      drain();

      // Reset in the middle of converting 144.
      send(8'd144, 1'b0);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_eq("midrst_out_valid", int'(out_valid), 0);
      check_eq("midrst_in_ready", int'(in_ready), 1);
      check_eq("midrst_digits", int'({bcd_hundreds, bcd_tens, bcd_ones}), 0);
      check_eq("midrst_digit_en", int'(digit_en), 0);
      @(negedge clk);
      in_valid = 1'b1;
      bin_in   = 8'd49;
      @(negedge clk);
      rst_n = 1'b1;
      n0 = acc_count;
      @(negedge clk);
      check_eq("first_edge_accept", acc_count - n0, 1);
      check_eq("first_edge_cycle", last_acc_cyc, cyc);
      in_valid = 1'b0;
      seen = 0;
      for (int i = 0; i < 7; i++) begin
         if (out_valid) seen++;
         @(negedge clk);
      end
      check_eq("aborted_no_valid", seen, 0);
      drain();

      // Full sweep with random output stalls and busy-time noise.
      rand_stall = 1'b1;
      for (int v = 0; v < 256; v++) send(8'(v), 1'b1);
      drain();
      rand_stall = 1'b0;
      out_ready  = 1'b1;
      drain();
      check_eq("scoreboard_empty", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
